// File: rtl/flopshare_arb.sv
`default_nettype none
// ============================================================================
// Module   : flopshare_arb
// Brief    : Round-robin arbiter feeding N requesters into one shared staging
//            register. Optional lock feature: FLOPSHARE_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module flopshare_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       ReqValid,
    input  logic [N*WIDTH-1:0] ReqData,
`ifdef FLOPSHARE_ARB_LOCK_EN
    input  logic [N-1:0]       ReqLock,
`endif
    output logic [N-1:0]       ReqReady,
    output logic               OutValid,
    output logic [WIDTH-1:0]   OutData,
    output logic [IDXW-1:0]    OutIdx,
    input  logic               OutReady
);

    localparam logic [IDXW:0]   N_EXT    = (IDXW+1)'(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N-1);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDXW-1:0]  out_idx_q,   out_idx_d;
    logic [IDXW-1:0]  ptr_q,       ptr_d;
`ifdef FLOPSHARE_ARB_LOCK_EN
    logic             locked_q,    locked_d;
    logic [IDXW-1:0]  owner_q,     owner_d;
`endif

    logic             accept;
    logic [N-1:0]     eligible;
    logic [N-1:0]     grant_vec;
    logic             grant_any;
    logic [IDXW-1:0]  grant_idx;
    logic [IDXW:0]    search_idx;
    logic [IDXW-1:0]  ptr_next;

    // Rotating priority search; reset gates grants so X inputs cannot leak in.
    always_comb begin
        accept     = !reset && (!out_valid_q || OutReady);
        eligible   = ReqValid;
`ifdef FLOPSHARE_ARB_LOCK_EN
        if (locked_q) begin
            eligible = ReqValid & (N'(1) << owner_q);
        end
`endif
        grant_vec  = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                search_idx = {1'b0, ptr_q} + (IDXW+1)'(k);
                if (search_idx >= N_EXT) begin
                    search_idx = search_idx - N_EXT;
                end
                if (!grant_any && eligible[search_idx[IDXW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = search_idx[IDXW-1:0];
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;
`ifdef FLOPSHARE_ARB_LOCK_EN
        locked_d    = locked_q;
        owner_d     = owner_q;
`endif
        if (grant_any) begin
            out_valid_d = 1'b1;
            out_data_d  = ReqData[grant_idx*WIDTH +: WIDTH];
            out_idx_d   = grant_idx;
            ptr_d       = ptr_next;
`ifdef FLOPSHARE_ARB_LOCK_EN
            // A locking grant pins the owner and freezes rotation until released.
            if (ReqLock[grant_idx]) begin
                locked_d = 1'b1;
                owner_d  = grant_idx;
                ptr_d    = ptr_q;
            end else begin
                locked_d = 1'b0;
            end
`endif
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
`ifdef FLOPSHARE_ARB_LOCK_EN
            locked_q    <= 1'b0;
            owner_q     <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
`ifdef FLOPSHARE_ARB_LOCK_EN
            locked_q    <= locked_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign ReqReady = grant_vec;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign OutIdx   = out_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_flopshare_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_flopshare_arb
// Brief    : Directed self-checking bench for flopshare_arb (N=4, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flopshare_arb;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 2;

    logic               clk;
    logic               reset;
    logic [N-1:0]       ReqValid;
    logic [N*WIDTH-1:0] ReqData;
    logic [N-1:0]       ReqLock;
    logic [N-1:0]       ReqReady;
    logic               OutValid;
    logic [WIDTH-1:0]   OutData;
    logic [IDXW-1:0]    OutIdx;
    logic               OutReady;

    int checks   = 0;
    int failures = 0;

    flopshare_arb #(.N(N), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .ReqValid (ReqValid),
        .ReqData  (ReqData),
`ifdef FLOPSHARE_ARB_LOCK_EN
        .ReqLock  (ReqLock),
`endif
        .ReqReady (ReqReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutIdx   (OutIdx),
        .OutReady (OutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ReqValid = 4'b1111;
        ReqData  = 32'h13121110;
        ReqLock  = '0;
        OutReady = 1'b1;
        step();
        step();
        checks++; if (ReqReady !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", ReqReady); end
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", OutValid); end
        checks++; if (OutData !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", OutData); end
        checks++; if (OutIdx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", OutIdx); end
    endtask

    task automatic test_single();
        reset    = 1'b0;
        ReqValid = 4'b0100;
        ReqData  = 32'h13A51110;
        #1;
        checks++; if (ReqReady !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", ReqReady); end
        step();
        checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", OutValid); end
        checks++; if (OutData !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", OutData); end
        checks++; if (OutIdx !== 2'd2) begin failures++; $display("FAIL single_idx got=%0d exp=2", OutIdx); end
        // Pointer now 3: requester 3 must win a full request set.
        ReqData  = 32'h13121110;
        ReqValid = 4'b1111;
        #1;
        checks++; if (ReqReady !== 4'b1000) begin failures++; $display("FAIL single_ptr3 got=%b exp=1000", ReqReady); end
        step();
        checks++; if (OutIdx !== 2'd3) begin failures++; $display("FAIL single_idx3 got=%0d exp=3", OutIdx); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rdy;
        logic [7:0] exp_data;
        for (int k = 0; k < 5; k++) begin
            exp_rdy  = 4'b0001 << (k % 4);
            exp_data = 8'h10 + 8'(k % 4);
            checks++; if (ReqReady !== exp_rdy) begin failures++; $display("FAIL rot_ready[%0d] got=%b exp=%b", k, ReqReady, exp_rdy); end
            step();
            checks++; if (OutIdx !== 2'(k % 4) || OutData !== exp_data || OutValid !== 1'b1) begin
                failures++; $display("FAIL rot_out[%0d] got=idx%0d/%h/v%b exp=idx%0d/%h/v1", k, OutIdx, OutData, OutValid, k % 4, exp_data);
            end
        end
    endtask

    task automatic test_backpressure();
        step();  // grants requester 1, pointer moves to 2
        checks++; if (OutIdx !== 2'd1 || OutData !== 8'h11) begin failures++; $display("FAIL bp_setup got=idx%0d/%h exp=idx1/11", OutIdx, OutData); end
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ReqReady !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, ReqReady); end
            step();
            checks++; if (OutValid !== 1'b1 || OutData !== 8'h11 || OutIdx !== 2'd1) begin
                failures++; $display("FAIL bp_hold[%0d] got=idx%0d/%h/v%b exp=idx1/11/v1", k, OutIdx, OutData, OutValid);
            end
        end
        OutReady = 1'b1;
        #1;
        checks++; if (ReqReady !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", ReqReady); end
        step();
        checks++; if (OutValid !== 1'b1 || OutData !== 8'h12 || OutIdx !== 2'd2) begin
            failures++; $display("FAIL bp_refill got=idx%0d/%h/v%b exp=idx2/12/v1", OutIdx, OutData, OutValid);
        end
    endtask

    task automatic test_drain();
        ReqValid = 4'b0000;
        #1;
        checks++; if (ReqReady !== 4'b0000) begin failures++; $display("FAIL drain_ready got=%b exp=0000", ReqReady); end
        step();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", OutValid); end
        checks++; if (OutIdx !== 2'd2 || OutData !== 8'h12) begin failures++; $display("FAIL drain_hold got=idx%0d/%h exp=idx2/12", OutIdx, OutData); end
        // Pointer must still be 3 after the empty cycle.
        ReqValid = 4'b1001;
        #1;
        checks++; if (ReqReady !== 4'b1000) begin failures++; $display("FAIL drain_ptr got=%b exp=1000", ReqReady); end
        step();
        checks++; if (OutIdx !== 2'd3 || OutValid !== 1'b1) begin failures++; $display("FAIL drain_next got=idx%0d/v%b exp=idx3/v1", OutIdx, OutValid); end
    endtask

    task automatic test_async_reset();
        ReqValid = 4'b0100;
        step();  // grants requester 2, pointer moves to 3
        checks++; if (OutIdx !== 2'd2 || OutData !== 8'h12) begin failures++; $display("FAIL ar_setup got=idx%0d/%h exp=idx2/12", OutIdx, OutData); end
        ReqValid = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (OutValid !== 1'b0 || OutData !== 8'h00 || OutIdx !== 2'd0) begin
            failures++; $display("FAIL ar_clear got=idx%0d/%h/v%b exp=idx0/00/v0", OutIdx, OutData, OutValid);
        end
        checks++; if (ReqReady !== 4'b0000) begin failures++; $display("FAIL ar_ready got=%b exp=0000", ReqReady); end
        step();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL ar_hold_valid got=%b exp=0", OutValid); end
        reset    = 1'b0;
        ReqValid = 4'b1010;
        #1;
        checks++; if (ReqReady !== 4'b0010) begin failures++; $display("FAIL ar_first got=%b exp=0010", ReqReady); end
        step();
        checks++; if (OutIdx !== 2'd1 || OutData !== 8'h11 || OutValid !== 1'b1) begin
            failures++; $display("FAIL ar_out got=idx%0d/%h/v%b exp=idx1/11/v1", OutIdx, OutData, OutValid);
        end
    endtask

`ifdef FLOPSHARE_ARB_LOCK_EN
    task automatic test_lock();
        ReqValid = 4'b1000;
        ReqLock  = 4'b1000;
        #1;
        checks++; if (ReqReady !== 4'b1000) begin failures++; $display("FAIL lock_grant got=%b exp=1000", ReqReady); end
        step();
        ReqValid = 4'b0111;
        ReqLock  = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (ReqReady !== 4'b0000) begin failures++; $display("FAIL lock_block[%0d] got=%b exp=0000", k, ReqReady); end
            step();
        end
        ReqValid = 4'b1111;
        #1;
        checks++; if (ReqReady !== 4'b1000) begin failures++; $display("FAIL lock_owner got=%b exp=1000", ReqReady); end
        step();
        checks++; if (ReqReady !== 4'b0001) begin failures++; $display("FAIL lock_release got=%b exp=0001", ReqReady); end
        step();
        checks++; if (OutIdx !== 2'd0) begin failures++; $display("FAIL lock_next got=%0d exp=0", OutIdx); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_drain();
        test_async_reset();
`ifdef FLOPSHARE_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
